// File: rtl/gpio_debounce.sv
// GPIO input conditioner: two-flop synchronizer, shared sample prescaler and per-bit
// stability counters that accept a level only after NSTABLE consecutive differing ticks.
module gpio_debounce #(
    parameter int unsigned     NIN         = 16,
    parameter int unsigned     DIVIDER     = 1000,
    parameter int unsigned     NSTABLE     = 4,
    parameter logic [NIN-1:0]  RESET_VALUE = '0
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [NIN-1:0]  i_gpio_raw,
    output logic [NIN-1:0]  o_gpio,
    output logic [NIN-1:0]  o_rise,
    output logic [NIN-1:0]  o_fall,
    output logic            o_tick
);

    localparam int unsigned PW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int unsigned CW = (NSTABLE > 1) ? $clog2(NSTABLE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIVIDER - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(NSTABLE - 1);

    logic [NIN-1:0] s1_q;
    logic [NIN-1:0] s2_q;
    logic [PW-1:0]  pre_q;
    logic           tick_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_q <= RESET_VALUE;
            s2_q <= RESET_VALUE;
        end else begin
            s1_q <= i_gpio_raw;
            s2_q <= s1_q;
        end
    end

    // Registered tick: visible during the cycle after the wrap, and it gates the counters
    // on the following edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else if (pre_q == PRE_MAX) begin
            pre_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            pre_q  <= pre_q + PW'(1);
            tick_q <= 1'b0;
        end
    end

    assign o_tick = tick_q;

    for (genvar i = 0; i < NIN; i++) begin : g_bit
        logic [CW-1:0] cnt_q;
        logic          lvl_q;
        logic          rise_q;
        logic          fall_q;
        logic          differ;
        logic          done;

        always_comb begin
            differ = s2_q[i] != lvl_q;
            done   = differ && (cnt_q == CNT_MAX);
        end

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                cnt_q  <= '0;
                lvl_q  <= RESET_VALUE[i];
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (tick_q) begin
                    if (!differ) begin
                        cnt_q <= '0;
                    end else if (done) begin
                        cnt_q  <= '0;
                        lvl_q  <= s2_q[i];
                        rise_q <= s2_q[i];
                        fall_q <= ~s2_q[i];
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            end
        end

        assign o_gpio[i] = lvl_q;
        assign o_rise[i] = rise_q;
        assign o_fall[i] = fall_q;
    end

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: four instances with different prescale/stability settings,
// a window-based reference model checked every cycle, plus hand-computed checkpoints.
module tb_gpio_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst_n;
    logic [15:0] raw   [4];
    logic [15:0] dgpio [4];
    logic [15:0] drise [4];
    logic [15:0] dfall [4];
    logic        dtick [4];

    gpio_debounce #(.NIN(16), .DIVIDER(4), .NSTABLE(3), .RESET_VALUE(16'h00F0)) u_d0 (
        .i_clk(clk), .i_reset_n(rst_n[0]), .i_gpio_raw(raw[0]),
        .o_gpio(dgpio[0]), .o_rise(drise[0]), .o_fall(dfall[0]), .o_tick(dtick[0])
    );
    gpio_debounce #(.NIN(16), .DIVIDER(1), .NSTABLE(4), .RESET_VALUE(16'h0000)) u_d1 (
        .i_clk(clk), .i_reset_n(rst_n[1]), .i_gpio_raw(raw[1]),
        .o_gpio(dgpio[1]), .o_rise(drise[1]), .o_fall(dfall[1]), .o_tick(dtick[1])
    );
    gpio_debounce #(.NIN(16), .DIVIDER(1), .NSTABLE(2), .RESET_VALUE(16'h0000)) u_d2 (
        .i_clk(clk), .i_reset_n(rst_n[2]), .i_gpio_raw(raw[2]),
        .o_gpio(dgpio[2]), .o_rise(drise[2]), .o_fall(dfall[2]), .o_tick(dtick[2])
    );
    gpio_debounce #(.NIN(16), .DIVIDER(1), .NSTABLE(8), .RESET_VALUE(16'h0000)) u_d3 (
        .i_clk(clk), .i_reset_n(rst_n[3]), .i_gpio_raw(raw[3]),
        .o_gpio(dgpio[3]), .o_rise(drise[3]), .o_fall(dfall[3]), .o_tick(dtick[3])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Reference model: tick at the n-th edge after release when n % DIVIDER == 0; a bit
    // flips once its last NSTABLE tick samples all disagree with the current level.
    int          m_div [4];
    int          m_nst [4];
    logic [15:0] m_rv  [4];
    logic [15:0] m_out [4];
    logic [15:0] m_rise[4];
    logic [15:0] m_fall[4];
    logic        m_tick[4];
    int          m_n   [4];
    logic [15:0] rh_last[4];
    logic [15:0] rh_prev[4];
    logic [15:0] hist  [4][8];
    int          nval  [4];
    int          rise_cnt[4][16];
    int          fall_cnt[4][16];

    task automatic model_reset(input int i);
        m_out[i]   = m_rv[i];
        m_rise[i]  = '0;
        m_fall[i]  = '0;
        m_tick[i]  = 1'b0;
        m_n[i]     = 0;
        rh_last[i] = m_rv[i];
        rh_prev[i] = m_rv[i];
        nval[i]    = 0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            if (!rst_n[i]) begin
                model_reset(i);
            end else begin
                logic [15:0] acc;
                acc = '0;
                if (m_tick[i]) begin
                    for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
                    hist[i][0] = rh_prev[i];
                    if (nval[i] < 8) nval[i]++;
                    for (int b = 0; b < 16; b++) begin
                        logic all_diff;
                        all_diff = (nval[i] >= m_nst[i]);
                        for (int j = 0; j < m_nst[i]; j++)
                            if (hist[i][j][b] == m_out[i][b]) all_diff = 1'b0;
                        acc[b] = all_diff;
                    end
                end
                m_out[i]   = m_out[i] ^ acc;
                m_rise[i]  = acc & m_out[i];
                m_fall[i]  = acc & ~m_out[i];
                m_n[i]     = m_n[i] + 1;
                m_tick[i]  = (m_n[i] % m_div[i]) == 0;
                rh_prev[i] = rh_last[i];
                rh_last[i] = raw[i];
            end
        end
    endtask

    initial begin
        m_div = '{4, 1, 1, 1};
        m_nst = '{3, 4, 2, 8};
        m_rv  = '{16'h00F0, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            model_reset(i);
            for (int b = 0; b < 16; b++) begin
                rise_cnt[i][b] = 0;
                fall_cnt[i][b] = 0;
            end
        end
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                chk16($sformatf("m%0d_gpio", i), dgpio[i], m_out[i]);
                chk16($sformatf("m%0d_rise", i), drise[i], m_rise[i]);
                chk16($sformatf("m%0d_fall", i), dfall[i], m_fall[i]);
                chk16($sformatf("m%0d_tick", i), {15'b0, dtick[i]}, {15'b0, m_tick[i]});
                for (int b = 0; b < 16; b++) begin
                    if (drise[i][b]) rise_cnt[i][b]++;
                    if (dfall[i][b]) fall_cnt[i][b]++;
                end
            end
        end
    end

    // Lands 1 time unit after the n-th following falling edge, i.e. after the n-th rising edge.
    task automatic go(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int base;

    initial begin
        rst_n  = 4'b0000;
        raw[0] = 16'h00F0;
        raw[1] = '0;
        raw[2] = '0;
        raw[3] = '0;
        go(2);

        // Reset values and tick cadence, DIVIDER=4
        rst_n[0] = 1'b1;
        chk16("t1_gpio_rst", dgpio[0], 16'h00F0);
        chk16("t1_tick_rst", {15'b0, dtick[0]}, 16'h0000);
        go(3);
        chk16("t1_tick_e3", {15'b0, dtick[0]}, 16'h0000);
        go(1);
        chk16("t1_tick_e4", {15'b0, dtick[0]}, 16'h0001);
        chk16("t1_rise_e4", drise[0], 16'h0000);
        go(1);
        chk16("t1_tick_e5", {15'b0, dtick[0]}, 16'h0000);
        go(3);
        chk16("t1_tick_e8", {15'b0, dtick[0]}, 16'h0001);
        chk16("t1_gpio_e8", dgpio[0], 16'h00F0);

        // Bounce on bit 7 (starts at 1), DIVIDER=4 NSTABLE=3
        base = fall_cnt[0][7];
        for (int k = 0; k < 12; k++) begin
            raw[0][7] = ~raw[0][7];
            go(5);
        end
        chk16("t4_bounce_lvl", {15'b0, dgpio[0][7]}, 16'h0001);
        chk16("t4_bounce_fall", 16'(fall_cnt[0][7] - base), 16'd0);
        raw[0][7] = 1'b0;
        go(14);
        chk16("t4_settle_lvl", {15'b0, dgpio[0][7]}, 16'h0000);
        chk16("t4_settle_fall", 16'(fall_cnt[0][7] - base), 16'd1);

        // Single rise on bit 3, DIVIDER=1 NSTABLE=4
        rst_n[1] = 1'b1;
        go(9);
        raw[1][3] = 1'b1;
        go(5);
        chk16("t2_gpio_e14", dgpio[1], 16'h0000);
        go(1);
        chk16("t2_gpio_e15", dgpio[1], 16'h0008);
        chk16("t2_rise_e15", drise[1], 16'h0008);
        chk16("t2_fall_e15", dfall[1], 16'h0000);
        go(1);
        chk16("t2_rise_e16", drise[1], 16'h0000);

        // Glitch rejection on bit 0
        base = rise_cnt[1][0];
        raw[1][0] = 1'b1;
        go(3);
        raw[1][0] = 1'b0;
        go(5);
        raw[1][0] = 1'b1;
        go(2);
        raw[1][0] = 1'b0;
        go(6);
        chk16("t3_glitch_gpio", dgpio[1], 16'h0008);
        chk16("t3_glitch_rise", 16'(rise_cnt[1][0] - base), 16'd0);
        raw[1][0] = 1'b1;
        go(5);
        chk16("t3_hold_e5", dgpio[1], 16'h0008);
        go(1);
        chk16("t3_hold_e6", dgpio[1], 16'h0009);
        chk16("t3_hold_rise", 16'(rise_cnt[1][0] - base), 16'd1);

        // Simultaneous changes, DIVIDER=1 NSTABLE=2
        rst_n[2] = 1'b1;
        go(2);
        raw[2] = 16'hA5A5;
        go(3);
        chk16("t5_gpio_e3", dgpio[2], 16'h0000);
        go(1);
        chk16("t5_gpio_a", dgpio[2], 16'hA5A5);
        chk16("t5_rise_a", drise[2], 16'hA5A5);
        chk16("t5_fall_a", dfall[2], 16'h0000);
        raw[2] = 16'h5A5A;
        go(3);
        chk16("t5_gpio_b3", dgpio[2], 16'hA5A5);
        go(1);
        chk16("t5_gpio_b", dgpio[2], 16'h5A5A);
        chk16("t5_rise_b", drise[2], 16'h5A5A);
        chk16("t5_fall_b", dfall[2], 16'hA5A5);

        // Reset mid-count, DIVIDER=1 NSTABLE=8
        rst_n[3] = 1'b1;
        go(2);
        raw[3][2] = 1'b1;
        go(5);
        rst_n[3] = 1'b0;
        #1;
        chk16("t6_gpio_rst", dgpio[3], 16'h0000);
        chk16("t6_rise_rst", drise[3], 16'h0000);
        go(3);
        rst_n[3] = 1'b1;
        go(9);
        chk16("t6_gpio_e9", dgpio[3], 16'h0000);
        go(1);
        chk16("t6_gpio_e10", dgpio[3], 16'h0004);
        chk16("t6_rise_e10", drise[3], 16'h0004);
        go(2);
        chk16("t6_rise_total", 16'(rise_cnt[3][2]), 16'd1);

        go(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
